// File: rtl/fsm_ctrl_pkg.sv
// Shared definitions for the FSM stimulus sequencer.
//   - op_e         : program entry opcodes (bits [5:4] of a program word)
//   - ctrl_state_e : sequencer controller states
//   - FSM_STATE_W / FINAL_CODE : default geometry of the controlled FSMs
package fsm_ctrl_pkg;

  localparam int unsigned FSM_STATE_W = 17;
  localparam int unsigned FINAL_CODE  = 4100;

  typedef enum logic [1:0] {
    OP_STEP = 2'b00,
    OP_MARK = 2'b01,
    OP_BACK = 2'b10,
    OP_END  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/stim_prog_ram.sv
// Program store for the stimulus sequencer: DEPTH x 6 register file.
//   clk   : clock
//   we    : synchronous write enable
//   waddr : write address
//   wdata : write data {op[1:0], vec[3:0]}
//   raddr : asynchronous read address
//   rdata : asynchronous read data
// Contents are not reset.
module stim_prog_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [5:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [5:0]    rdata
);

  logic [5:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_stim_sequencer.sv
// Programmable stimulus controller for a pattern-recognition FSM.
// Stores a short program of 4-bit vectors, resets the target FSM, replays the
// vectors one per clock on i1..i4 (with one MARK/BACK repeat loop) and reports
// whether the FSM reached FINAL_CODE before END or the step budget ran out.
//   clk, reset          : clock, synchronous active-high reset
//   prog_we/addr/data   : program write port (IDLE only), data = {op, i4..i1}
//   loop_n              : extra passes taken by BACK, latched at start
//   start               : begin a run (IDLE only)
//   fsm_state           : state code of the controlled FSM
//   fsm_reset           : reset to the controlled FSM (CLEAR cycle)
//   i1..i4              : registered stimulus bits
//   busy, done, matched : run status; done is a one-cycle pulse
//   step_count          : vectors driven in the last/current run
module fsm_stim_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned STATE_W    = fsm_ctrl_pkg::FSM_STATE_W,
  parameter int unsigned FINAL_CODE = fsm_ctrl_pkg::FINAL_CODE,
  parameter int unsigned MAX_STEPS  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [5:0]               prog_data,
  input  logic [3:0]               loop_n,
  input  logic                     start,
  input  logic [STATE_W-1:0]       fsm_state,
  output logic                     fsm_reset,
  output logic                     i1,
  output logic                     i2,
  output logic                     i3,
  output logic                     i4,
  output logic                     busy,
  output logic                     done,
  output logic                     matched,
  output logic [7:0]               step_count
);

  import fsm_ctrl_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  ctrl_state_e   state, state_nxt;
  op_e           fetch_op, cur_op;
  logic [AW-1:0] pc, pc_inc, pc_f;
  logic [AW-1:0] loop_pc, loop_pc_f;
  logic [3:0]    loop_cnt, loop_cnt_f, loop_n_q;
  logic [3:0]    vec;
  logic [5:0]    rdata;
  logic          fetch, hit, prog_wr;

  assign prog_wr = prog_we && (state == S_IDLE);

  stim_prog_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (prog_wr),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rdata)
  );

  assign hit      = (fsm_state == STATE_W'(FINAL_CODE));
  assign fetch_op = op_e'(rdata[5:4]);
  assign pc_inc   = (pc == AW'(DEPTH - 1)) ? '0 : pc + 1'b1;

  // pc addresses the entry that will be shown next. The entry is fetched and
  // its flow-control op resolved on the edge that loads it onto i1..i4, so
  // cur_op tells the RUN cycle only whether the vector on display is an END.
  always_comb begin
    pc_f       = pc_inc;
    loop_pc_f  = loop_pc;
    loop_cnt_f = loop_cnt;
    case (fetch_op)
      OP_MARK: begin
        loop_pc_f  = pc_inc;
        loop_cnt_f = '0;
      end
      OP_BACK: begin
        if (loop_cnt < loop_n_q) begin
          loop_cnt_f = loop_cnt + 4'd1;
          pc_f       = loop_pc;
        end
      end
      OP_END:  pc_f = pc;
      default: pc_f = pc_inc;
    endcase
  end

  // Match takes priority over END and timeout.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        fetch     = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (hit)                                state_nxt = S_DONE;
        else if (cur_op == OP_END)              state_nxt = S_DRAIN;
        else if (step_count == 8'(MAX_STEPS))   state_nxt = S_DONE;
        else                                    fetch     = 1'b1;
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      loop_pc    <= '0;
      loop_cnt   <= '0;
      loop_n_q   <= '0;
      cur_op     <= OP_STEP;
      vec        <= '0;
      matched    <= 1'b0;
      step_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        loop_n_q   <= loop_n;
        matched    <= 1'b0;
        step_count <= '0;
        pc         <= '0;
        loop_pc    <= '0;
        loop_cnt   <= '0;
      end
      if (fetch) begin
        vec        <= rdata[3:0];
        cur_op     <= fetch_op;
        pc         <= pc_f;
        loop_pc    <= loop_pc_f;
        loop_cnt   <= loop_cnt_f;
        step_count <= step_count + 8'd1;
      end
      if ((state == S_RUN || state == S_DRAIN) && hit) matched <= 1'b1;
      if (state_nxt == S_DONE) vec <= '0;
    end
  end

  assign busy      = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign fsm_reset = (state == S_CLEAR);
  assign i1        = vec[0];
  assign i2        = vec[1];
  assign i3        = vec[2];
  assign i4        = vec[3];

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
module tb_fsm_stim_sequencer;

  localparam int unsigned MAXS  = 20;
  localparam int unsigned FINAL = 4100;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       frst;
    logic       matched;
    logic [7:0] steps;
    logic [3:0] vec;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [5:0]  prog_data;
  logic [3:0]  loop_n;
  logic        start;
  logic [16:0] fsm_state;
  logic        fsm_reset, i1, i2, i3, i4, busy, done, matched;
  logic [7:0]  step_count;

  // Stand-in FSM: reports the final code while the driven vector equals key.
  logic        key_en;
  logic [3:0]  key;
  assign fsm_state = (key_en && {i4, i3, i2, i1} == key) ? 17'(FINAL)
                                                          : {13'h0A0, i4, i3, i2, i1};

  fsm_stim_sequencer #(
    .DEPTH      (16),
    .STATE_W    (17),
    .FINAL_CODE (FINAL),
    .MAX_STEPS  (MAXS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .loop_n     (loop_n),
    .start      (start),
    .fsm_state  (fsm_state),
    .fsm_reset  (fsm_reset),
    .i1         (i1),
    .i2         (i2),
    .i3         (i3),
    .i4         (i4),
    .busy       (busy),
    .done       (done),
    .matched    (matched),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          fails   = 0;
  bit          chk_en  = 0;
  obs_t        q[$];
  obs_t        mq[$];
  logic        exp_m;
  logic [7:0]  exp_s;
  logic [5:0]  prog [16];

  function automatic obs_t mk(input logic b, input logic d, input logic f,
                              input logic m, input logic [7:0] s, input logic [3:0] v);
    obs_t o;
    o.busy = b; o.done = d; o.frst = f; o.matched = m; o.steps = s; o.vec = v;
    return o;
  endfunction

  // Reference: walk the program by its rules and list the expected outputs
  // for every cycle from CLEAR to DONE.
  function automatic void model(input logic [3:0] ln, output logic m, output logic [7:0] ns);
    int pc = 0, lpc = 0, lcnt = 0;
    bit drain = 0;
    logic [3:0] vecs[$];
    logic [3:0] v;
    logic [1:0] op;
    m = 0;
    mq.delete();
    for (int k = 0; k < int'(MAXS); k++) begin
      v  = prog[pc][3:0];
      op = prog[pc][5:4];
      vecs.push_back(v);
      if (key_en && v == key) begin m = 1; break; end
      if (op == 2'b11) begin drain = 1; break; end
      if (op == 2'b01) begin
        lpc  = (pc + 1) % 16;
        lcnt = 0;
        pc   = (pc + 1) % 16;
      end else if (op == 2'b10 && lcnt < int'(ln)) begin
        lcnt = lcnt + 1;
        pc   = lpc;
      end else begin
        pc = (pc + 1) % 16;
      end
    end
    ns = 8'(vecs.size());
    mq.push_back(mk(1, 0, 1, 0, 0, 0));
    for (int k = 0; k < vecs.size(); k++) mq.push_back(mk(1, 0, 0, 0, 8'(k + 1), vecs[k]));
    if (drain) mq.push_back(mk(1, 0, 0, 0, ns, vecs[vecs.size() - 1]));
    mq.push_back(mk(0, 1, 0, m, ns, 0));
  endfunction

  // Monitor: each cycle compare against the next expected entry, or against
  // the idle outputs when no run is outstanding.
  always @(negedge clk) begin
    obs_t a, e;
    a = mk(busy, done, fsm_reset, matched, step_count, {i4, i3, i2, i1});
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (a !== e) begin
        fails++;
        $display("FAIL run_cycle t=%0t got b/d/r/m/steps/vec=%h want %h", $time, a, e);
      end
    end else if (chk_en) begin
      e = mk(0, 0, 0, exp_m, exp_s, 0);
      vectors++;
      if (a !== e) begin
        fails++;
        $display("FAIL idle t=%0t got b/d/r/m/steps/vec=%h want %h", $time, a, e);
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    prog_we = 1; prog_addr = a; prog_data = d; start = 0;
    prog[a] = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  task automatic idle(input int n);
    prog_we = 0; start = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run(input logic [3:0] ln, input bit disturb, input int abort_c,
                     input bit wr_also, input logic [3:0] wa, input logic [5:0] wd);
    logic       em;
    logic [7:0] es;
    start = 1; loop_n = ln; prog_we = wr_also; prog_addr = wa; prog_data = wd;
    if (wr_also) prog[wa] = wd;
    model(ln, em, es);
    @(posedge clk); #1;
    start = 0; prog_we = 0;
    foreach (mq[k]) q.push_back(mq[k]);
    exp_m = em; exp_s = es;
    for (int c = 1; c <= 300; c++) begin
      if (q.size() == 0) break;
      start = 0; prog_we = 0; reset = 0;
      if (disturb && c == 3) begin
        start = 1; prog_we = 1; prog_addr = 4'd1; prog_data = prog[1] ^ 6'h3F;
      end
      if (c == abort_c) reset = 1;
      @(posedge clk); #1;
      if (c == abort_c) begin
        reset = 0; q.delete(); exp_m = 0; exp_s = 0;
      end
    end
    if (q.size() != 0) begin
      fails++; vectors++;
      $display("FAIL run_bound got %0d pending cycles want 0", q.size());
      q.delete();
    end
    start = 0; prog_we = 0; reset = 0;
  endtask

  task automatic load_fill(input logic [5:0] d);
    for (int a = 0; a < 16; a++) wr(4'(a), d);
  endtask

  initial begin
    reset = 1; prog_we = 0; prog_addr = 0; prog_data = 0; loop_n = 0; start = 0;
    key_en = 0; key = 0; exp_m = 0; exp_s = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0; chk_en = 1;
    idle(2);

    // Basic match: FSM hits on the third vector.
    load_fill({2'b11, 4'hF});
    wr(0, {2'b00, 4'b0100}); wr(1, {2'b00, 4'b1001}); wr(2, {2'b00, 4'b0000});
    wr(3, {2'b00, 4'b0010}); wr(4, {2'b11, 4'b0000});
    key_en = 1; key = 4'b0000;
    run(0, 0, -1, 0, 0, 0);

    // Loop with two extra passes, then back-to-back identical run with
    // start/prog_we pulsed mid-run, then a rerun proving memory unchanged.
    key_en = 0;
    wr(0, {2'b01, 4'h1}); wr(1, {2'b00, 4'h2}); wr(2, {2'b10, 4'h0}); wr(3, {2'b11, 4'hE});
    run(2, 0, -1, 0, 0, 0);
    run(2, 1, -1, 0, 0, 0);
    run(2, 0, -1, 0, 0, 0);
    idle(1);

    // Write landing in the same cycle as start.
    run(2, 0, -1, 1, 4'd1, {2'b00, 4'h7});

    // Timeout: only STEP entries, wraps past entry 15.
    for (int a = 0; a < 16; a++) wr(4'(a), {2'b00, 4'(a ^ 5)});
    run(0, 0, -1, 0, 0, 0);

    // Reset while the sixth vector (index 5) is on the outputs, then rerun.
    run(0, 0, 7, 0, 0, 0);
    idle(2);
    run(0, 0, -1, 0, 0, 0);

    // Match on the END vector: DRAIN is skipped.
    wr(0, {2'b00, 4'h3}); wr(1, {2'b11, 4'h5});
    key_en = 1; key = 4'h5;
    run(0, 0, -1, 0, 0, 0);

    // Random programs.
    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < 16; a++) begin
        int unsigned w;
        logic [1:0]  op;
        w  = $urandom_range(0, 9);
        op = (w < 5) ? 2'b00 : (w < 7) ? 2'b01 : (w < 8) ? 2'b10 : 2'b11;
        wr(4'(a), {op, 4'($urandom)});
      end
      key_en = 1'($urandom);
      key    = 4'($urandom);
      run(4'($urandom_range(0, 3)), 0, -1, 0, 0, 0);
      if (r % 3 == 0) idle(1);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/fsm_stim_sequencer.md
# fsm_stim_sequencer

Programmable stimulus controller for the generated pattern-recognition FSMs. It stores a short program of 4-bit input vectors, resets the target FSM, and replays the vectors one per clock on `i1`..`i4`, honouring one repeat loop. It watches the FSM's 17-bit state-code output and reports whether the final state code was reached before the program ended or the step budget ran out. It sits beside each FSM instance as its sequencer in bench and on-board self-test.

## Interface
Parameters:
- `DEPTH`, 16: program entries; address width is log2(`DEPTH`).
- `STATE_W`, 17: width of the FSM state-code output.
- `FINAL_CODE`, 4100: state code that means the pattern was recognised.
- `MAX_STEPS`, 255: step budget per run; 8-bit counter.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high; one clock, and reset is synchronous and active-high.
- `prog_we`  in  1: program write strobe.
- `prog_addr`  in  4: program write address.
- `prog_data`  in  6: [3:0] = {i4,i3,i2,i1}; [5:4] = op (00 STEP, 01 MARK, 10 BACK, 11 END).
- `loop_n`  in  4: number of extra passes taken by BACK; sampled at `start`.
- `start`  in  1: begin a run; accepted only in IDLE.
- `fsm_state`  in  `STATE_W`: state-code output of the controlled FSM.
- `fsm_reset`  out  1: reset to the controlled FSM.
- `i1`, `i2`, `i3`, `i4`  out  1 each: registered stimulus bits.
- `busy`  out  1: high from the cycle after `start` acceptance until `done`.
- `done`  out  1: one-cycle pulse at the end of a run.
- `matched`  out  1: result of the last run, held until the next `start`.
- `step_count`  out  8: vectors driven in the last or current run.

## Operation
- Reset values: all outputs are 0, the state is IDLE, and `pc`, `loop_pc` and `loop_cnt` are 0. Program memory is not cleared.
- **IDLE**
  - `prog_we` writes `mem[prog_addr]`.
  - `start` latches `loop_n`, clears `matched`, `step_count` and `pc`, then goes to CLEAR.
  - `start` and `prog_we` in the same cycle: the write happens and the run starts.
- **CLEAR** (1 cycle): `fsm_reset`=1 and `i1`..`i4`=0. Next state is RUN.
- **RUN** (one entry per cycle)
  - Always: drive `mem[pc]` bits [3:0] on `i4`..`i1` and increment `step_count`.
  - STEP: `pc`+1.
  - MARK: `loop_pc`=`pc`+1, `loop_cnt`=0, `pc`+1.
  - BACK: if `loop_cnt` < latched `loop_n`, then `loop_cnt`+1 and `pc`=`loop_pc`; else `pc`+1.
  - END: go to DRAIN.
  - `pc`=`DEPTH`-1 with a non-END op: `pc` wraps to 0 and the run continues.
  - BACK with no prior MARK: jumps to `loop_pc`=0.
- **DRAIN** (1 cycle): stimulus held and `step_count` unchanged, so the FSM response to the last vector can be sampled.
- **Match check**: in RUN or DRAIN, if `fsm_state`==`FINAL_CODE`, then set `matched`=1 and go to DONE. This takes priority over END and over timeout in the same cycle.
- **Timeout**: in RUN, when `step_count` reaches `MAX_STEPS` without a match, go to DONE with `matched`=0.
- **DONE** (1 cycle): `done`=1, `busy`=0, `i1`..`i4`=0. Next state is IDLE.
- `start` outside IDLE is ignored. `prog_we` outside IDLE is ignored.
- `reset` mid-run returns to IDLE within one cycle; no `done` pulse is produced.

## Timing
- `start` accepted at edge T:
  - CLEAR occupies cycle T+1, with `busy`=1 and `fsm_reset`=1.
  - The first vector is valid on `i1`..`i4` in cycle T+2.
- Vector k (0-based) appears in cycle T+2+k.
- `fsm_state` is sampled in the same cycle as the vector; the FSM updates combinationally from state and inputs.
- END at cycle E: DRAIN is E+1 and `done` is E+2 (no match).
- Match seen in cycle M: `done` is M+1 and `matched` rises at M+1.
- Minimum run is START→CLEAR→RUN(END)→DRAIN→DONE, i.e. `done` 4 cycles after `start`.
- Back-to-back runs: `start` is accepted in the cycle after `done`.

## Structure
- Shared package `fsm_ctrl_pkg`:
  - Op encodings `OP_STEP`/`OP_MARK`/`OP_BACK`/`OP_END`.
  - Controller state encoding IDLE/CLEAR/RUN/DRAIN/DONE.
  - `FSM_STATE_W`=17 and `FINAL_CODE`=4100.
- One sub-module, `stim_prog_ram`: `DEPTH`x6 register file with one synchronous write port and one asynchronous read port (read address `pc`).
- Everything else (sequencer FSM, `pc`/loop registers, counters) lives in `fsm_stim_sequencer`.

## Test plan
- **Basic match**:
  - Program: STEP 0100 (i3), STEP 1001 (i4,i1), STEP 0000, STEP 0010 (i2), END.
  - FSM model reports 4100 at the 3rd vector.
  - Required: `matched`=1, `done` at `start`+5, `step_count`=3.
- **Loop**:
  - Program: MARK 0001, STEP 0010, BACK 0000, END; `loop_n`=2.
  - Required: vector order 1,2,0,2,0,2,0,(END vector); `step_count`=8; `matched`=0.
- **Timeout**: program of only STEP entries (wraps at 15→0), `MAX_STEPS`=20. Required: `done` after 20 vectors, `matched`=0.
- **Ignored writes and starts**:
  - `prog_we` and `start` asserted while `busy`: memory is unchanged and the run is unaffected.
  - Simultaneous `start`+`prog_we` in IDLE: the write lands and the run starts.
- **Reset mid-RUN** at vector 5: next cycle IDLE, all outputs 0, no `done` pulse. A new `start` then reruns from `pc`=0.
- **Priority**: `fsm_state`=4100 in the same cycle as the END entry. Required: `matched`=1 and `done` next cycle; DRAIN is skipped.
